load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 106 ++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time, issues it to memory and holds the completion
// until writeback takes it. Optional misaligned-access trap selected by MISALIGN_TRAP_EN.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_write,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_width,
  input  logic        in_extend,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_is_load,
  output logic        out_exc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_width,
  output logic        mem_extend,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        misaligned;
  logic        write_q, extend_q, is_load_q, exc_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [1:0]  width_q;
  logic [4:0]  rd_q;

  assign accept = in_valid & (state_q == StIdle);

  always_comb begin
    misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
    unique case (in_width)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_addr[0];
      default: misaligned = |in_addr[1:0];
    endcase
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = misaligned ? StResp : StReq;
      StReq:  if (mem_ack) state_d = StResp;
      StResp: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      width_q   <= 2'b00;
      extend_q  <= 1'b0;
      rd_q      <= 5'd0;
      is_load_q <= 1'b0;
      exc_q     <= 1'b0;
      data_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q   <= in_write;
        addr_q    <= in_addr;
        wdata_q   <= in_wdata;
        width_q   <= in_width;
        extend_q  <= in_extend;
        rd_q      <= in_rd;
        is_load_q <= ~in_write;
        exc_q     <= misaligned;
        // A trapped access completes with the faulting address as its result
        if (misaligned) data_q <= in_addr;
      end
      if (state_q == StReq && mem_ack) data_q <= write_q ? 32'h0 : mem_rdata;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign mem_req     = (state_q == StReq);
  assign out_valid   = (state_q == StResp);
  assign mem_addr    = addr_q;
  assign mem_write   = write_q;
  assign mem_wdata   = wdata_q;
  assign mem_width   = width_q;
  assign mem_extend  = extend_q;
  assign out_rd      = rd_q;
  assign out_is_load = is_load_q;
  assign out_exc     = exc_q;
  assign out_data    = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset/spurious-ack
// sequences and randomized accesses against a behavioural model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_write, in_extend;
  logic [31:0] in_addr, in_wdata;
  logic [1:0]  in_width;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_is_load, out_exc;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        mem_req, mem_write, mem_extend, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_width;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        extend;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          ack_dly;
    int          rdy_dly;
    logic [31:0] exp_data;
    logic        exp_exc;
  } acc_t;

  acc_t vec[6];

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_width(in_width), .in_extend(in_extend), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_is_load(out_is_load), .out_exc(out_exc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_extend(mem_extend), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference rules: alignment depends only on width and the low address bits
  function automatic logic model_mis(input logic [1:0] w, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if (w == 2'b01) return a % 2 != 0;
    if (w >= 2'b10) return a % 4 != 0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_data(input acc_t a);
    if (model_mis(a.width, a.addr)) return a.addr;
    return a.write ? 32'h0 : a.rdata;
  endfunction

  task automatic check_out(input string tag, input acc_t a);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".out_data"}, out_data, a.exp_data);
    check({tag, ".out_exc"}, 32'(out_exc), 32'(a.exp_exc));
    check({tag, ".out_rd"}, 32'(out_rd), 32'(a.rd));
    check({tag, ".out_is_load"}, 32'(out_is_load), 32'(!a.write));
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
  endtask

  task automatic run_access(input string tag, input acc_t a);
    int  cnt;
    bit  acked;
    @(negedge clk);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_write = a.write; in_addr = a.addr; in_wdata = a.wdata;
    in_width = a.width; in_extend = a.extend; in_rd = a.rd;
    @(negedge clk);
    in_valid = 1'b0;
    in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
    check({tag, ".mem_addr"}, mem_addr, a.addr);
    check({tag, ".mem_write"}, 32'(mem_write), 32'(a.write));
    check({tag, ".mem_wdata"}, mem_wdata, a.wdata);
    check({tag, ".mem_width"}, 32'(mem_width), 32'(a.width));
    check({tag, ".mem_extend"}, 32'(mem_extend), 32'(a.extend));
    if (a.exp_exc) begin
      check({tag, ".mis_no_req"}, 32'(mem_req), 32'd0);
    end else begin
      check({tag, ".req_at_e0"}, 32'(mem_req), 32'd1);
      cnt = 0; acked = 0;
      for (int i = 0; i < 20 && !acked; i++) begin
        if (mem_req) begin
          cnt++;
          if (cnt == a.ack_dly + 1) begin
            mem_ack = 1'b1; mem_rdata = a.rdata; acked = 1;
          end
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      check({tag, ".req_cycles"}, 32'(cnt), 32'(a.ack_dly + 1));
    end
    check_out(tag, a);
    for (int j = 0; j < a.rdy_dly; j++) begin
      @(negedge clk);
      check_out({tag, ".hold"}, a);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".done_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".done_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    acc_t r;
    reset = 1'b1; in_valid = 0; in_write = 0; in_addr = 0; in_wdata = 0; in_width = 0;
    in_extend = 0; in_rd = 0; out_ready = 0; mem_ack = 0; mem_rdata = 0;

    vec[0] = '{1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5'd5, 32'h8000_00FF, 1, 0,
               32'h8000_00FF, 1'b0};
    vec[1] = '{1'b1, 32'h13, 32'h0000_00A5, 2'b00, 1'b0, 5'd7, 32'hDEAD_BEEF, 1, 0,
               32'h0, 1'b0};
    vec[2] = '{1'b0, 32'h6, 32'h0, 2'b01, 1'b1, 5'd9, 32'h1234_ABCD, 2, 5,
               32'h1234_ABCD, 1'b0};
    vec[4] = '{1'b0, 32'h40, 32'h0, 2'b11, 1'b0, 5'd31, 32'h5555_AAAA, 3, 1,
               32'h5555_AAAA, 1'b0};
`ifdef MISALIGN_TRAP_EN
    vec[3] = '{1'b0, 32'h22, 32'h0, 2'b10, 1'b0, 5'd3, 32'hCAFE_F00D, 0, 0,
               32'h0000_0022, 1'b1};
    vec[5] = '{1'b1, 32'h1, 32'h0000_BEEF, 2'b01, 1'b0, 5'd1, 32'h0, 0, 2,
               32'h0000_0001, 1'b1};
`else
    vec[3] = '{1'b0, 32'h22, 32'h0, 2'b10, 1'b0, 5'd3, 32'hCAFE_F00D, 0, 0,
               32'hCAFE_F00D, 1'b0};
    vec[5] = '{1'b1, 32'h1, 32'h0000_BEEF, 2'b01, 1'b0, 5'd1, 32'h0, 0, 2,
               32'h0, 1'b0};
`endif

    // Reset values must appear without any clock edge
    #3;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_exc", 32'(out_exc), 32'd0);
    check("rst.mem_write", 32'(mem_write), 32'd0);
    check("rst.out_data", out_data, 32'h0);
    check("rst.out_is_load", 32'(out_is_load), 32'd0);
    check("rst.mem_addr", mem_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) run_access($sformatf("vec%0d", k), vec[k]);

    // Spurious ack in idle
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("spur.out_valid", 32'(out_valid), 32'd0);
    check("spur.in_ready", 32'(in_ready), 32'd1);
    check("spur.mem_req", 32'(mem_req), 32'd0);

    // Reset in the middle of a request
    in_valid = 1'b1; in_write = 1'b0; in_addr = 32'h100; in_width = 2'b10; in_rd = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstreq.mem_req_before", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rstreq.mem_req", 32'(mem_req), 32'd0);
    check("rstreq.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      check("rstreq.no_valid", 32'(out_valid), 32'd0);
      check("rstreq.no_req", 32'(mem_req), 32'd0);
    end

    // Randomized accesses against the model
    for (int k = 0; k < 40; k++) begin
      r.write   = 1'($urandom);
      r.width   = 2'($urandom);
      r.addr    = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      r.wdata   = $urandom;
      r.extend  = 1'($urandom);
      r.rd      = 5'($urandom);
      r.rdata   = $urandom;
      r.ack_dly = $urandom_range(0, 3);
      r.rdy_dly = $urandom_range(0, 3);
      r.exp_exc = model_mis(r.width, r.addr);
      r.exp_data = model_data(r);
      run_access($sformatf("rnd%0d", k), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
